// File: rtl/pipelined_instruction_decode_if.sv
// Handshake bundle between fetch (master), the decode FIFO (slave) and
// register read. The upstream side carries the instruction word and its
// extension mode. The downstream side carries the decoded head entry.
interface pipelined_instruction_decode_if #(
  parameter int INSTR_WIDTH = 32,
  parameter int OP_BITS     = 6,
  parameter int REG_BITS    = 5,
  parameter int FUNC_BITS   = 6,
  parameter int IMM_BITS    = 16,
  parameter int EXT_WIDTH   = 32,
  parameter int DEPTH       = 2
);
  logic                         in_valid;
  logic                         in_ready;
  logic [INSTR_WIDTH-1:0]       instr;
  logic [1:0]                   ext_sel;
  logic                         out_valid;
  logic                         out_ready;
  logic [OP_BITS-1:0]           opCode;
  logic [REG_BITS-1:0]          rt;
  logic [REG_BITS-1:0]          rs;
  logic [REG_BITS-1:0]          rd;
  logic [REG_BITS-1:0]          shmt;
  logic [FUNC_BITS-1:0]         func;
  logic [IMM_BITS-1:0]          imm;
  logic [EXT_WIDTH-1:0]         imm_ext;
  logic [$clog2(DEPTH+1)-1:0]   count;

  modport master (
    output in_valid, instr, ext_sel, out_ready,
    input  in_ready, out_valid, opCode, rt, rs, rd, shmt, func, imm, imm_ext, count
  );

  modport slave (
    input  in_valid, instr, ext_sel, out_ready,
    output in_ready, out_valid, opCode, rt, rs, rd, shmt, func, imm, imm_ext, count
  );
endinterface

// File: rtl/pipelined_instruction_decode.sv
// Buffered instruction decoder. Each accepted word is split into its fields
// and its immediate is extended at enqueue, so the FIFO holds fully decoded
// entries. The head entry is presented downstream straight from storage.
// Field order is the team encoding: opcode, rt, rs, rd, shmt, func (MSB->LSB).
module pipelined_instruction_decode #(
  parameter int INSTR_WIDTH = 32,
  parameter int OP_BITS     = 6,
  parameter int REG_BITS    = 5,
  parameter int FUNC_BITS   = 6,
  parameter int IMM_BITS    = 16,
  parameter int EXT_WIDTH   = 32,
  parameter int DEPTH       = 2
) (
  input  logic clock,
  input  logic reset_n,
  input  logic flush,
  pipelined_instruction_decode_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [OP_BITS-1:0]   op;
    logic [REG_BITS-1:0]  rt;
    logic [REG_BITS-1:0]  rs;
    logic [REG_BITS-1:0]  rd;
    logic [REG_BITS-1:0]  shmt;
    logic [FUNC_BITS-1:0] func;
    logic [IMM_BITS-1:0]  imm;
    logic [EXT_WIDTH-1:0] imm_ext;
  } entry_t;

  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            full_s, empty_s, push_s, pop_s;
  entry_t          new_s, head_s;

  // Immediate extension: 00 zero, 01 sign, 10 upper, 11 sign then <<2.
  function automatic logic [EXT_WIDTH-1:0] extend_imm(input logic [IMM_BITS-1:0] i,
                                                      input logic [1:0] sel);
    logic [EXT_WIDTH-1:0] sx;
    sx = {{(EXT_WIDTH-IMM_BITS){i[IMM_BITS-1]}}, i};
    case (sel)
      2'b00:   extend_imm = {{(EXT_WIDTH-IMM_BITS){1'b0}}, i};
      2'b01:   extend_imm = sx;
      2'b10:   extend_imm = {i, {(EXT_WIDTH-IMM_BITS){1'b0}}};
      2'b11:   extend_imm = {sx[EXT_WIDTH-3:0], 2'b00};
      default: extend_imm = '0;
    endcase
  endfunction

  // Pointer increment that wraps at DEPTH, valid for any depth.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) next_ptr = '0;
    else                     next_ptr = p + PW'(1);
  endfunction

  assign full_s  = (count_q == CW'(DEPTH));
  assign empty_s = (count_q == CW'(0));
  // A full FIFO refuses a push even when a pop happens in the same cycle.
  assign push_s  = bus.in_valid && !full_s;
  assign pop_s   = bus.out_ready && !empty_s;

  // Split the incoming word into fields and extend its immediate.
  always_comb begin
    new_s.op      = bus.instr[INSTR_WIDTH-1 -: OP_BITS];
    new_s.rt      = bus.instr[INSTR_WIDTH-OP_BITS-1 -: REG_BITS];
    new_s.rs      = bus.instr[INSTR_WIDTH-OP_BITS-REG_BITS-1 -: REG_BITS];
    new_s.rd      = bus.instr[INSTR_WIDTH-OP_BITS-2*REG_BITS-1 -: REG_BITS];
    new_s.shmt    = bus.instr[INSTR_WIDTH-OP_BITS-3*REG_BITS-1 -: REG_BITS];
    new_s.func    = bus.instr[FUNC_BITS-1:0];
    new_s.imm     = bus.instr[IMM_BITS-1:0];
    new_s.imm_ext = extend_imm(bus.instr[IMM_BITS-1:0], bus.ext_sel);
  end

  // Next FIFO state; flush wins over both push and pop.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_s) begin
        mem_d[wr_ptr_q] = new_s;
        wr_ptr_d        = next_ptr(wr_ptr_q);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = next_ptr(rd_ptr_q);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // FIFO state registers; reset clears storage so nothing survives it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Head entry, forced to zero whenever the FIFO is empty.
  always_comb begin
    if (empty_s) head_s = '0;
    else         head_s = mem_q[rd_ptr_q];
  end

  assign bus.in_ready  = !full_s;
  assign bus.out_valid = !empty_s;
  assign bus.count     = count_q;
  assign bus.opCode    = head_s.op;
  assign bus.rt        = head_s.rt;
  assign bus.rs        = head_s.rs;
  assign bus.rd        = head_s.rd;
  assign bus.shmt      = head_s.shmt;
  assign bus.func      = head_s.func;
  assign bus.imm       = head_s.imm;
  assign bus.imm_ext   = head_s.imm_ext;
endmodule

// File: tb/tb_pipelined_instruction_decode.sv
// Bench for pipelined_instruction_decode (default parameters, DEPTH=2).
// A queue of accepted (word, mode) pairs stands in for the FIFO; expected
// fields are computed from the word with plain division and modulo.
module tb_pipelined_instruction_decode;
  localparam int DEPTH = 2;

  logic clock;
  logic reset_n;
  logic flush;

  typedef struct {
    int unsigned w;
    int unsigned sel;
  } item_t;

  item_t model_q[$];
  int    checks;
  int    failures;

  pipelined_instruction_decode_if bus();

  pipelined_instruction_decode dut (
    .clock   (clock),
    .reset_n (reset_n),
    .flush   (flush),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned ref_ext(input int unsigned w, input int unsigned sel);
    int unsigned imm;
    int          sv;
    imm = w % 65536;
    sv  = (imm >= 32768) ? int'(imm) - 65536 : int'(imm);
    case (sel)
      0:       return imm;
      1:       return int'(sv);
      2:       return imm * 65536;
      default: return int'(sv * 4);
    endcase
  endfunction

  // Compare every output with what the queue says the head should be.
  task automatic check_all();
    int unsigned w, s;
    bit          v;
    v = (model_q.size() != 0);
    check_eq("out_valid", bus.out_valid, v);
    check_eq("in_ready", bus.in_ready, model_q.size() != DEPTH);
    check_eq("count", bus.count, model_q.size());
    w = v ? model_q[0].w : 0;
    s = v ? model_q[0].sel : 0;
    check_eq("opCode", bus.opCode, v ? w / (1 << 26) : 0);
    check_eq("rt", bus.rt, v ? (w / (1 << 21)) % 32 : 0);
    check_eq("rs", bus.rs, v ? (w / (1 << 16)) % 32 : 0);
    check_eq("rd", bus.rd, v ? (w / (1 << 11)) % 32 : 0);
    check_eq("shmt", bus.shmt, v ? (w / (1 << 6)) % 32 : 0);
    check_eq("func", bus.func, v ? w % 64 : 0);
    check_eq("imm", bus.imm, v ? w % 65536 : 0);
    check_eq("imm_ext", bus.imm_ext, v ? ref_ext(w, s) : 0);
  endtask

  // Drive one cycle of inputs, advance the model at the edge, check after it.
  task automatic step(input bit v, input logic [31:0] w, input logic [1:0] e,
                      input bit ordy, input bit fl);
    bit push_ok, pop_ok;
    bus.in_valid  = v;
    bus.instr     = w;
    bus.ext_sel   = e;
    bus.out_ready = ordy;
    flush         = fl;
    @(posedge clock);
    if (fl) begin
      model_q.delete();
    end else begin
      push_ok = v && (model_q.size() < DEPTH);
      pop_ok  = ordy && (model_q.size() > 0);
      if (pop_ok)  void'(model_q.pop_front());
      if (push_ok) model_q.push_back('{w: w, sel: e});
    end
    @(negedge clock);
    check_all();
  endtask

  logic [31:0] ext_exp [4];

  initial begin
    checks   = 0;
    failures = 0;
    reset_n  = 1'b0;
    flush    = 1'b0;
    bus.in_valid  = 1'b0;
    bus.instr     = '0;
    bus.ext_sel   = 2'b00;
    bus.out_ready = 1'b0;
    ext_exp[0] = 32'h0000FFFC;
    ext_exp[1] = 32'hFFFFFFFC;
    ext_exp[2] = 32'hFFFC0000;
    ext_exp[3] = 32'hFFFFFFF0;

    // Reset state.
    @(negedge clock);
    check_all();
    @(negedge clock);
    reset_n = 1'b1;
    check_all();

    // Immediate extension in all four modes (push and pop together after the first).
    for (int m = 0; m < 4; m++) begin
      step(1'b1, 32'h8C22FFFC, 2'(m), 1'b1, 1'b0);
      check_eq("t1_op", bus.opCode, 6'h23);
      check_eq("t1_rt", bus.rt, 5'd1);
      check_eq("t1_rs", bus.rs, 5'd2);
      check_eq("t1_imm", bus.imm, 16'hFFFC);
      check_eq("t1_ext", bus.imm_ext, ext_exp[m]);
    end
    step(1'b0, 32'h0, 2'b00, 1'b1, 1'b0);

    // R-type split with one-cycle latency.
    step(1'b1, 32'h012A4020, 2'b00, 1'b0, 1'b0);
    check_eq("t2_valid", bus.out_valid, 1'b1);
    check_eq("t2_op", bus.opCode, 6'h00);
    check_eq("t2_rt", bus.rt, 5'd9);
    check_eq("t2_rs", bus.rs, 5'd10);
    check_eq("t2_rd", bus.rd, 5'd8);
    check_eq("t2_shmt", bus.shmt, 5'd0);
    check_eq("t2_func", bus.func, 6'h20);
    step(1'b0, 32'h0, 2'b00, 1'b1, 1'b0);

    // Back-pressure: third word held until the consumer drains.
    step(1'b1, 32'h11111111, 2'b01, 1'b0, 1'b0);
    step(1'b1, 32'h22222222, 2'b10, 1'b0, 1'b0);
    check_eq("t3_full_rdy", bus.in_ready, 1'b0);
    check_eq("t3_full_cnt", bus.count, 2'd2);
    step(1'b1, 32'h33338888, 2'b11, 1'b0, 1'b0);
    step(1'b1, 32'h33338888, 2'b11, 1'b1, 1'b0);
    step(1'b1, 32'h33338888, 2'b11, 1'b1, 1'b0);
    check_eq("t3_third_head", bus.instr == 32'h33338888 && bus.imm == 16'h8888, 1'b1);
    step(1'b0, 32'h0, 2'b00, 1'b1, 1'b0);

    // Steady push+pop: occupancy stays at one while pointers wrap.
    step(1'b1, $urandom, 2'($urandom_range(0, 3)), 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, $urandom, 2'($urandom_range(0, 3)), 1'b1, 1'b0);
      check_eq("t4_cnt", bus.count, 2'd1);
    end
    step(1'b0, 32'h0, 2'b00, 1'b1, 1'b0);

    // Flush from full with a simultaneous offered push.
    step(1'b1, 32'hAAAA5555, 2'b01, 1'b0, 1'b0);
    step(1'b1, 32'hBBBB6666, 2'b10, 1'b0, 1'b0);
    step(1'b1, 32'hCCCC7777, 2'b11, 1'b1, 1'b1);
    check_eq("t5_cnt", bus.count, 2'd0);
    check_eq("t5_valid", bus.out_valid, 1'b0);
    check_eq("t5_ext", bus.imm_ext, 32'h0);
    step(1'b0, 32'h0, 2'b00, 1'b0, 1'b0);

    // Asynchronous reset mid-operation.
    step(1'b1, 32'hDEADBEEF, 2'b01, 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check_eq("t6_valid", bus.out_valid, 1'b0);
    check_eq("t6_cnt", bus.count, 2'd0);
    model_q.delete();
    @(negedge clock);
    reset_n = 1'b1;
    check_eq("t6_rdy", bus.in_ready, 1'b1);
    check_all();

    // Randomized traffic with occasional flush.
    for (int i = 0; i < 500; i++) begin
      step($urandom_range(0, 3) != 0, $urandom, 2'($urandom_range(0, 3)),
           $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
